// File: rtl/gobou_ctrl_seq_if.sv
// Request/strobe bus between the ninjin-side register block and gobou_ctrl_seq.
//  master: issues req with qd/qo/offsets, observes busy/ack, addresses and MAC strobes.
//  slave : the sequencer; consumes the request, drives everything else.
interface gobou_ctrl_seq_if #(
  parameter int unsigned LWIDTH  = 10,
  parameter int unsigned IMGSIZE = 12,
  parameter int unsigned WTSIZE  = 16
);
  logic               req;
  logic [LWIDTH-1:0]  qd;
  logic [LWIDTH-1:0]  qo;
  logic [IMGSIZE-1:0] in_offset;
  logic [WTSIZE-1:0]  w_offset;
  logic               busy;
  logic               ack;
  logic [IMGSIZE-1:0] mem_addr;
  logic [WTSIZE-1:0]  wt_addr;
  logic               out_begin;
  logic               out_valid;
  logic               out_end;

  modport master (
    output req, qd, qo, in_offset, w_offset,
    input  busy, ack, mem_addr, wt_addr, out_begin, out_valid, out_end
  );

  modport slave (
    input  req, qd, qo, in_offset, w_offset,
    output busy, ack, mem_addr, wt_addr, out_begin, out_valid, out_end
  );
endinterface

// File: rtl/gobou_ctrl_seq.sv
// Upstream sequencer for the gobou MAC control path. Per request it walks qo
// output neurons, issuing qd input/weight read addresses per neuron, and emits
// begin/valid/end strobes delayed by RDLAT so they line up with returned data.
//  clk, rst : clock, asynchronous active-high reset
//  bus      : slave side of gobou_ctrl_seq_if (req/qd/qo/offsets in;
//             busy/ack/mem_addr/wt_addr/out_begin/out_valid/out_end out)
module gobou_ctrl_seq #(
  parameter int unsigned LWIDTH  = 10,
  parameter int unsigned IMGSIZE = 12,
  parameter int unsigned WTSIZE  = 16,
  parameter int unsigned RDLAT   = 1,
  parameter int unsigned DRAIN   = 3
) (
  input logic             clk,
  input logic             rst,
  gobou_ctrl_seq_if.slave bus
);
  localparam int unsigned DWIDTH = (DRAIN > 1) ? $clog2(DRAIN) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_BEGIN, S_STREAM, S_END, S_DRAIN, S_DONE
  } state_t;

  state_t             state;
  logic [LWIDTH-1:0]  qd_q, qo_q;
  logic [LWIDTH-1:0]  i_cnt, o_cnt;
  logic [DWIDTH-1:0]  d_cnt;
  logic [IMGSIZE-1:0] in_off_q;
  logic [IMGSIZE-1:0] mem_addr;
  logic [WTSIZE-1:0]  wt_addr;
  logic [WTSIZE-1:0]  wt_ptr;
  logic               busy, ack;
  logic               raw_begin, raw_valid, raw_end;

  // Sequencer FSM; strobes and addresses are registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      qd_q      <= '0;
      qo_q      <= '0;
      i_cnt     <= '0;
      o_cnt     <= '0;
      d_cnt     <= '0;
      in_off_q  <= '0;
      mem_addr  <= '0;
      wt_addr   <= '0;
      wt_ptr    <= '0;
      busy      <= 1'b0;
      ack       <= 1'b0;
      raw_begin <= 1'b0;
      raw_valid <= 1'b0;
      raw_end   <= 1'b0;
    end else begin
      raw_begin <= 1'b0;
      raw_valid <= 1'b0;
      raw_end   <= 1'b0;
      ack       <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (bus.req) begin
            qd_q      <= bus.qd;
            qo_q      <= bus.qo;
            in_off_q  <= bus.in_offset;
            wt_ptr    <= bus.w_offset;
            o_cnt     <= '0;
            busy      <= 1'b1;
            state     <= S_BEGIN;
            // An empty job spends one cycle in BEGIN without a strobe, then finishes.
            raw_begin <= (bus.qo != '0);
          end
        end
        S_BEGIN: begin
          if (qo_q == '0) begin
            state <= S_DONE;
            ack   <= 1'b1;
          end else if (qd_q != '0) begin
            state     <= S_STREAM;
            raw_valid <= 1'b1;
            i_cnt     <= '0;
            mem_addr  <= in_off_q;
            wt_addr   <= wt_ptr;
            wt_ptr    <= wt_ptr + WTSIZE'(1);
          end else begin
            state   <= S_END;
            raw_end <= 1'b1;
          end
        end
        S_STREAM: begin
          if (i_cnt == qd_q - LWIDTH'(1)) begin
            state   <= S_END;
            raw_end <= 1'b1;
          end else begin
            i_cnt     <= i_cnt + LWIDTH'(1);
            raw_valid <= 1'b1;
            mem_addr  <= mem_addr + IMGSIZE'(1);
            // Weight pointer keeps running across neurons: w_offset + o*qd + i.
            wt_addr   <= wt_ptr;
            wt_ptr    <= wt_ptr + WTSIZE'(1);
          end
        end
        S_END: begin
          state <= S_DRAIN;
          d_cnt <= '0;
        end
        S_DRAIN: begin
          if (d_cnt == DWIDTH'(DRAIN - 1)) begin
            if (o_cnt == qo_q - LWIDTH'(1)) begin
              state <= S_DONE;
              ack   <= 1'b1;
            end else begin
              o_cnt     <= o_cnt + LWIDTH'(1);
              state     <= S_BEGIN;
              raw_begin <= 1'b1;
            end
          end else begin
            d_cnt <= d_cnt + DWIDTH'(1);
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Strobe delay line matching the memory read latency.
  logic [2:0] raw_strb, out_strb;
  assign raw_strb = {raw_begin, raw_valid, raw_end};

  generate
    if (RDLAT == 0) begin : g_nodly
      assign out_strb = raw_strb;
    end else begin : g_dly
      logic [2:0] dly_q [RDLAT];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int unsigned k = 0; k < RDLAT; k++) dly_q[k] <= '0;
        end else begin
          dly_q[0] <= raw_strb;
          for (int unsigned k = 1; k < RDLAT; k++) dly_q[k] <= dly_q[k-1];
        end
      end
      assign out_strb = dly_q[RDLAT-1];
    end
  endgenerate

  assign bus.busy      = busy;
  assign bus.ack       = ack;
  assign bus.mem_addr  = mem_addr;
  assign bus.wt_addr   = wt_addr;
  assign bus.out_begin = out_strb[2];
  assign bus.out_valid = out_strb[1];
  assign bus.out_end   = out_strb[0];
endmodule
